mem_sequencer: RTL and testbench

Multi-cycle RAM access sequencer that sits directly between the control unit and the memory_data_register/RAM pair. It accepts a single read or write request, latches the address, drives RAM chip-select, output-enable and write-enable with configurable wait states, and drives the MDR enable/ctrl lines. On reads the MDR captures RAM data (ctrl 01); on writes the MDR drives the RAM bus (ctrl 11). It guarantees the shared 16-bit RAM bus is never driven by RAM and MDR in the same cycle.

---
 rtl/mem_sequencer_if.sv | 27 ++
 rtl/mem_sequencer.sv | 129 ++++++++++++
 tb/tb_mem_sequencer.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/mem_sequencer_if.sv
// Control-unit side bundle of the RAM access sequencer: request inputs plus
// the RAM strobes and MDR steering outputs it produces.
interface mem_sequencer_if #(
  parameter int unsigned ADDR_W = 16
);
  logic              req;
  logic              rw;
  logic [ADDR_W-1:0] addr_in;
  logic              busy;
  logic              done;
  logic [ADDR_W-1:0] ram_addr;
  logic              ram_cs;
  logic              ram_oe;
  logic              ram_we;
  logic              mdr_enable;
  logic [1:0]        mdr_ctrl;

  modport master (
    output req, rw, addr_in,
    input  busy, done, ram_addr, ram_cs, ram_oe, ram_we, mdr_enable, mdr_ctrl
  );

  modport slave (
    input  req, rw, addr_in,
    output busy, done, ram_addr, ram_cs, ram_oe, ram_we, mdr_enable, mdr_ctrl
  );
endinterface

// File: rtl/mem_sequencer.sv
// Multi-cycle RAM read/write sequencer with configurable wait states; steers
// the MDR so RAM and MDR never drive the shared data bus in the same cycle.
module mem_sequencer #(
  parameter int unsigned ADDR_W      = 16,
  parameter int unsigned WAIT_STATES = 2
) (
  input  logic            clk,
  input  logic            clr,
  mem_sequencer_if.slave  bus
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_WAIT,
    ST_XFER,
    ST_DONE
  } state_t;

  localparam logic [3:0] WAIT_INIT = 4'(WAIT_STATES);
  localparam logic [1:0] MDR_LOAD  = 2'b01;
  localparam logic [1:0] MDR_DRIVE = 2'b11;

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic              rw_q, rw_d;

  logic              busy_o;
  logic              done_o;
  logic              cs_o;
  logic              oe_o;
  logic              we_o;
  logic              mdr_en_o;
  logic [1:0]        mdr_ctrl_o;

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      ram_addr_q <= '0;
      rw_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      ram_addr_q <= ram_addr_d;
      rw_q       <= rw_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    ram_addr_d = ram_addr_q;
    rw_d       = rw_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.req) begin
          ram_addr_d = bus.addr_in;
          rw_d       = bus.rw;
          cnt_d      = WAIT_INIT;
          state_d    = ST_ADDR;
        end
      end
      ST_ADDR: begin
        // Writes always take at least one WAIT cycle so the we strobe exists.
        if (rw_q || (cnt_q != 4'd0)) state_d = ST_WAIT;
        else                         state_d = ST_XFER;
      end
      ST_WAIT: begin
        if (cnt_q <= 4'd1) state_d = ST_XFER;
        if (cnt_q != 4'd0) cnt_d = cnt_q - 4'd1;
      end
      ST_XFER: state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs depend only on state and the latched request type.
  always_comb begin
    busy_o     = 1'b0;
    done_o     = 1'b0;
    cs_o       = 1'b0;
    oe_o       = 1'b0;
    we_o       = 1'b0;
    mdr_en_o   = 1'b0;
    mdr_ctrl_o = 2'b00;
    case (state_q)
      ST_ADDR, ST_WAIT: begin
        busy_o = 1'b1;
        cs_o   = 1'b1;
        if (rw_q) begin
          mdr_en_o   = 1'b1;
          mdr_ctrl_o = MDR_DRIVE;
          we_o       = (state_q == ST_WAIT);
        end else begin
          oe_o = 1'b1;
        end
      end
      ST_XFER: begin
        busy_o   = 1'b1;
        cs_o     = 1'b1;
        mdr_en_o = 1'b1;
        if (rw_q) begin
          mdr_ctrl_o = MDR_DRIVE;
        end else begin
          oe_o       = 1'b1;
          mdr_ctrl_o = MDR_LOAD;
        end
      end
      ST_DONE: begin
        busy_o = 1'b1;
        done_o = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.busy       = busy_o;
  assign bus.done       = done_o;
  assign bus.ram_addr   = ram_addr_q;
  assign bus.ram_cs     = cs_o;
  assign bus.ram_oe     = oe_o;
  assign bus.ram_we     = we_o;
  assign bus.mdr_enable = mdr_en_o;
  assign bus.mdr_ctrl   = mdr_ctrl_o;

endmodule

// File: tb/tb_mem_sequencer.sv
// Directed bench for mem_sequencer: one instance with 2 wait states (index 0)
// and one with 0 wait states (index 1), each with a small RAM and MDR model.
module tb_mem_sequencer;

  logic clk = 1'b0;
  logic clr;
  always #5 clk = ~clk;

  mem_sequencer_if #(.ADDR_W(16)) bus_a ();
  mem_sequencer_if #(.ADDR_W(16)) bus_b ();

  mem_sequencer #(.ADDR_W(16), .WAIT_STATES(2)) dut_a (.clk(clk), .clr(clr), .bus(bus_a));
  mem_sequencer #(.ADDR_W(16), .WAIT_STATES(0)) dut_b (.clk(clk), .clr(clr), .bus(bus_b));

  int checks = 0;
  int errors = 0;

  // RAM/MDR models sharing a data bus per instance.
  logic [15:0] mdr_a, mdr_b;
  logic [15:0] ram_a [256];
  logic [15:0] ram_b [256];
  logic [15:0] dbus_a, dbus_b;
  logic        ld = 1'b0;
  logic [7:0]  ld_idx = '0;
  logic [15:0] ld_mdr = '0, ld_ram = '0;

  assign dbus_a = bus_a.ram_oe ? ram_a[bus_a.ram_addr[7:0]] :
                  (bus_a.mdr_enable && bus_a.mdr_ctrl == 2'b11) ? mdr_a : 16'h0000;
  assign dbus_b = bus_b.ram_oe ? ram_b[bus_b.ram_addr[7:0]] :
                  (bus_b.mdr_enable && bus_b.mdr_ctrl == 2'b11) ? mdr_b : 16'h0000;

  always @(posedge clk) begin
    if (ld) begin
      mdr_a <= ld_mdr; mdr_b <= ld_mdr;
      ram_a[ld_idx] <= ld_ram; ram_b[ld_idx] <= ld_ram;
    end else begin
      if (bus_a.mdr_enable && bus_a.mdr_ctrl == 2'b01) mdr_a <= dbus_a;
      if (bus_a.ram_we) ram_a[bus_a.ram_addr[7:0]] <= dbus_a;
      if (bus_b.mdr_enable && bus_b.mdr_ctrl == 2'b01) mdr_b <= dbus_b;
      if (bus_b.ram_we) ram_b[bus_b.ram_addr[7:0]] <= dbus_b;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Bus-safety monitor, active once the first reset has been applied.
  logic mon_en = 1'b0;
  always @(negedge clk) begin
    if (mon_en) begin
      chk("safe_oe_vs_drive_a", {31'd0, bus_a.ram_oe && bus_a.mdr_enable && bus_a.mdr_ctrl == 2'b11}, 32'd0);
      chk("safe_oe_vs_drive_b", {31'd0, bus_b.ram_oe && bus_b.mdr_enable && bus_b.mdr_ctrl == 2'b11}, 32'd0);
      chk("safe_we_a", {31'd0, bus_a.ram_we && !(bus_a.mdr_enable && bus_a.mdr_ctrl == 2'b11)}, 32'd0);
      chk("safe_we_b", {31'd0, bus_b.ram_we && !(bus_b.mdr_enable && bus_b.mdr_ctrl == 2'b11)}, 32'd0);
      chk("mdr_idle_a", {31'd0, bus_a.mdr_enable && !bus_a.busy}, 32'd0);
      chk("mdr_idle_b", {31'd0, bus_b.mdr_enable && !bus_b.busy}, 32'd0);
    end
  end

  // {busy, done, cs, oe, we, mdr_enable, mdr_ctrl[1:0]}
  function automatic logic [7:0] outs(input int d);
    if (d == 0)
      return {bus_a.busy, bus_a.done, bus_a.ram_cs, bus_a.ram_oe, bus_a.ram_we, bus_a.mdr_enable, bus_a.mdr_ctrl};
    else
      return {bus_b.busy, bus_b.done, bus_b.ram_cs, bus_b.ram_oe, bus_b.ram_we, bus_b.mdr_enable, bus_b.mdr_ctrl};
  endfunction

  function automatic logic [15:0] raddr(input int d);
    return (d == 0) ? bus_a.ram_addr : bus_b.ram_addr;
  endfunction

  task automatic drive(input int d, input logic r, input logic w, input logic [15:0] a);
    if (d == 0) begin bus_a.req = r; bus_a.rw = w; bus_a.addr_in = a; end
    else        begin bus_b.req = r; bus_b.rw = w; bus_b.addr_in = a; end
  endtask

  task automatic preload(input logic [15:0] a, input logic [15:0] m, input logic [15:0] r);
    @(negedge clk);
    ld = 1'b1; ld_idx = a[7:0]; ld_mdr = m; ld_ram = r;
    @(negedge clk);
    ld = 1'b0;
  endtask

  typedef struct {
    string            name;
    int               d;
    logic             rw;
    logic [15:0]      addr;
    logic [15:0]      pre_mdr;
    logic [15:0]      pre_ram;
    logic [15:0]      exp_data;
    int unsigned      n;
    logic [0:6][7:0]  exp;
  } vec_t;

  vec_t vecs [5];

  initial begin
    vecs[0] = '{name:"rd_ws2",   d:0, rw:1'b0, addr:16'h1234, pre_mdr:16'h0000, pre_ram:16'hBEEF, exp_data:16'hBEEF, n:6,
                exp:'{8'hB0, 8'hB0, 8'hB0, 8'hB5, 8'hC0, 8'h00, 8'h00}};
    vecs[1] = '{name:"wr_ws2",   d:0, rw:1'b1, addr:16'h00FF, pre_mdr:16'hA5A5, pre_ram:16'h0000, exp_data:16'hA5A5, n:6,
                exp:'{8'hA7, 8'hAF, 8'hAF, 8'hA7, 8'hC0, 8'h00, 8'h00}};
    vecs[2] = '{name:"rd_ws0",   d:1, rw:1'b0, addr:16'h0ABC, pre_mdr:16'h0000, pre_ram:16'h1357, exp_data:16'h1357, n:4,
                exp:'{8'hB0, 8'hB5, 8'hC0, 8'h00, 8'h00, 8'h00, 8'h00}};
    vecs[3] = '{name:"wr_ws0",   d:1, rw:1'b1, addr:16'h0042, pre_mdr:16'h5A5A, pre_ram:16'h0000, exp_data:16'h5A5A, n:5,
                exp:'{8'hA7, 8'hAF, 8'hA7, 8'hC0, 8'h00, 8'h00, 8'h00}};
    vecs[4] = '{name:"rd_ws2_b", d:0, rw:1'b0, addr:16'hFF80, pre_mdr:16'h0000, pre_ram:16'h2468, exp_data:16'h2468, n:6,
                exp:'{8'hB0, 8'hB0, 8'hB0, 8'hB5, 8'hC0, 8'h00, 8'h00}};

    clr = 1'b1;
    drive(0, 1'b0, 1'b0, 16'h0000);
    drive(1, 1'b0, 1'b0, 16'h0000);

    // Reset held for two cycles.
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk($sformatf("reset_outs_a_%0d", i), {24'd0, outs(0)}, 32'h0);
      chk($sformatf("reset_outs_b_%0d", i), {24'd0, outs(1)}, 32'h0);
      chk($sformatf("reset_addr_a_%0d", i), {16'd0, raddr(0)}, 32'h0);
    end
    clr = 1'b0;
    mon_en = 1'b1;
    @(negedge clk);
    chk("post_reset_outs_a", {24'd0, outs(0)}, 32'h0);
    chk("post_reset_addr_b", {16'd0, raddr(1)}, 32'h0);

    for (int v = 0; v < 5; v++) begin
      preload(vecs[v].addr, vecs[v].pre_mdr, vecs[v].pre_ram);
      drive(vecs[v].d, 1'b1, vecs[v].rw, vecs[v].addr);
      @(negedge clk);
      drive(vecs[v].d, 1'b0, ~vecs[v].rw, 16'hDEAD);
      for (int unsigned c = 0; c < vecs[v].n; c++) begin
        chk($sformatf("%s_outs_c%0d", vecs[v].name, c + 1), {24'd0, outs(vecs[v].d)}, {24'd0, vecs[v].exp[c]});
        chk($sformatf("%s_addr_c%0d", vecs[v].name, c + 1), {16'd0, raddr(vecs[v].d)}, {16'd0, vecs[v].addr});
        chk($sformatf("%s_other_idle_c%0d", vecs[v].name, c + 1), {24'd0, outs(1 - vecs[v].d)}, 32'h0);
        @(negedge clk);
      end
      if (vecs[v].rw == 1'b0)
        chk($sformatf("%s_mdr", vecs[v].name), {16'd0, (vecs[v].d == 0) ? mdr_a : mdr_b}, {16'd0, vecs[v].exp_data});
      else
        chk($sformatf("%s_ram", vecs[v].name),
            {16'd0, (vecs[v].d == 0) ? ram_a[vecs[v].addr[7:0]] : ram_b[vecs[v].addr[7:0]]},
            {16'd0, vecs[v].exp_data});
    end

    // Mid-idle reset clears the latched address left by the last accesses.
    @(negedge clk);
    chk("idle_addr_held_a", {16'd0, raddr(0)}, 32'h0000FF80);
    clr = 1'b1;
    @(negedge clk);
    @(negedge clk);
    clr = 1'b0;
    chk("midreset_addr_a", {16'd0, raddr(0)}, 32'h0);
    chk("midreset_addr_b", {16'd0, raddr(1)}, 32'h0);
    chk("midreset_outs_a", {24'd0, outs(0)}, 32'h0);

    // Inputs wiggled during a busy read are ignored; a held req is taken from IDLE.
    preload(16'h1234, 16'h0000, 16'hBEEF);
    drive(0, 1'b1, 1'b0, 16'h1234);
    @(negedge clk);
    for (int c = 0; c < 5; c++) begin
      chk($sformatf("ign_outs_c%0d", c + 1), {24'd0, outs(0)}, {24'd0, vecs[0].exp[c]});
      chk($sformatf("ign_addr_c%0d", c + 1), {16'd0, raddr(0)}, 32'h00001234);
      drive(0, (c >= 4) ? 1'b1 : ((c % 2) == 0), 1'b1, 16'h5555);
      @(negedge clk);
    end
    chk("ign_idle_outs", {24'd0, outs(0)}, 32'h0);
    chk("ign_idle_addr", {16'd0, raddr(0)}, 32'h00001234);
    @(negedge clk);
    drive(0, 1'b0, 1'b0, 16'h0000);
    for (int c = 0; c < 5; c++) begin
      chk($sformatf("ign_next_outs_c%0d", c + 1), {24'd0, outs(0)}, {24'd0, vecs[1].exp[c]});
      chk($sformatf("ign_next_addr_c%0d", c + 1), {16'd0, raddr(0)}, 32'h00005555);
      @(negedge clk);
    end
    chk("ign_next_ram", {16'd0, ram_a[8'h55]}, 32'h0000BEEF);

    // Reset in write cycle 2 aborts with no trailing done.
    preload(16'h0077, 16'hA5A5, 16'h0000);
    drive(0, 1'b1, 1'b1, 16'h0077);
    @(negedge clk);
    drive(0, 1'b0, 1'b0, 16'h0000);
    chk("abort_c1", {24'd0, outs(0)}, 32'h000000A7);
    @(negedge clk);
    chk("abort_c2", {24'd0, outs(0)}, 32'h000000AF);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    chk("abort_outs", {24'd0, outs(0)}, 32'h0);
    chk("abort_addr", {16'd0, raddr(0)}, 32'h0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk($sformatf("abort_quiet_%0d", c), {24'd0, outs(0)}, 32'h0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
